// File: rtl/uart_word_pkg.sv
// Shared definitions for the UART word codec: FSM state encoding and sizing helpers.
package uart_word_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned num_words(input int unsigned w, input int unsigned bpw);
        return (w + bpw - 1) / bpw;
    endfunction

endpackage

// File: rtl/uart_word_rx_core.sv
// UART receiver: samples frames mid-bit and reassembles NUM_WORDS chunks into one word.
module uart_word_rx_core
    import uart_word_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 868,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned W_OUT            = 24
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             rx_i,
    output logic             m_valid_o,
    output logic [W_OUT-1:0] m_data_o
);

    localparam int unsigned NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
    localparam int unsigned PadW      = NUM_WORDS * BITS_PER_WORD;
    localparam int unsigned ClkW      = cnt_width(CLOCKS_PER_PULSE);
    localparam int unsigned BitW      = cnt_width(BITS_PER_WORD);
    localparam int unsigned ChunkW    = cnt_width(NUM_WORDS);

    localparam logic [ClkW-1:0]   ClkLast   = ClkW'(CLOCKS_PER_PULSE - 1);
    localparam logic [ClkW-1:0]   HalfLast  = ClkW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [BitW-1:0]   DataLast  = BitW'(BITS_PER_WORD - 1);
    localparam logic [ChunkW-1:0] ChunkLast = ChunkW'(NUM_WORDS - 1);

    uart_state_e              state_q;
    logic                     rx_meta_q;
    logic                     rx_sync_q;
    logic [ClkW-1:0]          clk_cnt_q;
    logic [BitW-1:0]          bit_cnt_q;
    logic [ChunkW-1:0]        chunk_cnt_q;
    logic [BITS_PER_WORD-1:0] shreg_q;
    logic [PadW-1:0]          word_q;
    logic                     m_valid_q;
    logic [W_OUT-1:0]         m_data_q;
    logic [PadW-1:0]          asm_word;
    logic                     bit_done;

    assign bit_done = (clk_cnt_q == ClkLast);

    // Word as it looks once the chunk in shreg_q is written at the current index.
    always_comb begin
        asm_word = word_q;
        asm_word[int'(chunk_cnt_q) * BITS_PER_WORD +: BITS_PER_WORD] = shreg_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            chunk_cnt_q <= '0;
            shreg_q     <= '0;
            word_q      <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            m_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!rx_sync_q) begin
                        clk_cnt_q <= '0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (clk_cnt_q == HalfLast) begin
                        clk_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        state_q   <= rx_sync_q ? StIdle : StData;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + ClkW'(1);
                    end
                end
                StData: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        shreg_q   <= {rx_sync_q, shreg_q[BITS_PER_WORD-1:1]};
                        if (bit_cnt_q == DataLast) begin
                            state_q <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + ClkW'(1);
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        clk_cnt_q <= '0;
                        state_q   <= StIdle;
                        if (!rx_sync_q) begin
                            chunk_cnt_q <= '0;
                        end else if (chunk_cnt_q == ChunkLast) begin
                            chunk_cnt_q <= '0;
                            word_q      <= asm_word;
                            m_data_q    <= asm_word[W_OUT-1:0];
                            m_valid_q   <= 1'b1;
                        end else begin
                            chunk_cnt_q <= chunk_cnt_q + ChunkW'(1);
                            word_q      <= asm_word;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + ClkW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;

endmodule

// File: rtl/uart_word_tx_core.sv
// UART transmitter: serialises one W_OUT-bit word as NUM_WORDS back-to-back frames.
module uart_word_tx_core
    import uart_word_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 868,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned W_OUT            = 24,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             s_valid_i,
    input  logic [W_OUT-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             tx_o
);

    localparam int unsigned NUM_WORDS = num_words(W_OUT, BITS_PER_WORD);
    localparam int unsigned PadW      = NUM_WORDS * BITS_PER_WORD;
    localparam int unsigned ClkW      = cnt_width(CLOCKS_PER_PULSE);
    localparam int unsigned BitW      =
        cnt_width((BITS_PER_WORD > STOP_BITS) ? BITS_PER_WORD : STOP_BITS);
    localparam int unsigned ChunkW    = cnt_width(NUM_WORDS);

    localparam logic [ClkW-1:0]   ClkLast   = ClkW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BitW-1:0]   DataLast  = BitW'(BITS_PER_WORD - 1);
    localparam logic [BitW-1:0]   StopLast  = BitW'(STOP_BITS - 1);
    localparam logic [ChunkW-1:0] ChunkLast = ChunkW'(NUM_WORDS - 1);

    uart_state_e       state_q;
    logic [PadW-1:0]   data_q;
    logic [ClkW-1:0]   clk_cnt_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic [ChunkW-1:0] chunk_cnt_q;
    logic              tx_q;
    logic              ready_q;
    logic              bit_done;

    assign bit_done = (clk_cnt_q == ClkLast);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= StIdle;
            data_q      <= '0;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            chunk_cnt_q <= '0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
        end else begin
            if (state_q != StIdle) begin
                clk_cnt_q <= bit_done ? '0 : clk_cnt_q + ClkW'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (s_valid_i) begin
                        data_q      <= PadW'(s_data_i);
                        chunk_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        tx_q        <= 1'b0;
                        ready_q     <= 1'b0;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        tx_q    <= data_q[0];
                        data_q  <= data_q >> 1;
                        state_q <= StData;
                    end
                end
                StData: begin
                    // data_q shifts across the whole word, so the next chunk lands at bit 0.
                    if (bit_done) begin
                        if (bit_cnt_q == DataLast) begin
                            bit_cnt_q <= '0;
                            tx_q      <= 1'b1;
                            state_q   <= StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                            tx_q      <= data_q[0];
                            data_q    <= data_q >> 1;
                        end
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        if (bit_cnt_q == StopLast) begin
                            bit_cnt_q <= '0;
                            if (chunk_cnt_q == ChunkLast) begin
                                ready_q <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                chunk_cnt_q <= chunk_cnt_q + ChunkW'(1);
                                tx_q        <= 1'b0;
                                state_q     <= StStart;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s_ready_o = ready_q;
    assign tx_o      = tx_q;

endmodule

// File: rtl/uart_word_codec.sv
// Full-duplex UART word codec: independent transmit and receive cores on one clock.
module uart_word_codec
    import uart_word_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_PULSE = 868,
    parameter int unsigned BITS_PER_WORD    = 8,
    parameter int unsigned W_OUT            = 24,
    parameter int unsigned STOP_BITS        = 1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             s_valid_i,
    input  logic [W_OUT-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             tx_o,
    input  logic             rx_i,
    output logic             m_valid_o,
    output logic [W_OUT-1:0] m_data_o
);

    uart_word_tx_core #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .W_OUT           (W_OUT),
        .STOP_BITS       (STOP_BITS)
    ) u_tx (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .s_valid_i(s_valid_i),
        .s_data_i (s_data_i),
        .s_ready_o(s_ready_o),
        .tx_o     (tx_o)
    );

    uart_word_rx_core #(
        .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
        .BITS_PER_WORD   (BITS_PER_WORD),
        .W_OUT           (W_OUT)
    ) u_rx (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .rx_i     (rx_i),
        .m_valid_o(m_valid_o),
        .m_data_o (m_data_o)
    );

endmodule

// File: tb/tb_uart_word_codec.sv
// Bench for uart_word_codec: a 24-bit/1-stop instance and a 12-bit/2-stop instance.
module tb_uart_word_codec;

    localparam int unsigned Cpp = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        a_s_valid;
    logic [23:0] a_s_data;
    logic        a_s_ready;
    logic        a_tx;
    logic        a_rx;
    logic        a_m_valid;
    logic [23:0] a_m_data;
    logic        a_loop;
    logic        a_rx_drv;

    logic        b_s_valid;
    logic [11:0] b_s_data;
    logic        b_s_ready;
    logic        b_tx;
    logic        b_m_valid;
    logic [11:0] b_m_data;

    assign a_rx = a_loop ? a_tx : a_rx_drv;

    uart_word_codec #(
        .CLOCKS_PER_PULSE(Cpp),
        .BITS_PER_WORD   (8),
        .W_OUT           (24),
        .STOP_BITS       (1)
    ) dut_a (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .s_valid_i(a_s_valid),
        .s_data_i (a_s_data),
        .s_ready_o(a_s_ready),
        .tx_o     (a_tx),
        .rx_i     (a_rx),
        .m_valid_o(a_m_valid),
        .m_data_o (a_m_data)
    );

    uart_word_codec #(
        .CLOCKS_PER_PULSE(Cpp),
        .BITS_PER_WORD   (8),
        .W_OUT           (12),
        .STOP_BITS       (2)
    ) dut_b (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .s_valid_i(b_s_valid),
        .s_data_i (b_s_data),
        .s_ready_o(b_s_ready),
        .tx_o     (b_tx),
        .rx_i     (b_tx),
        .m_valid_o(b_m_valid),
        .m_data_o (b_m_data)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Receive-side monitors: count m_valid cycles and log the words.
    int          a_mv_cnt = 0;
    int          b_mv_cnt = 0;
    logic [23:0] a_mq[$];
    always @(negedge clk) begin
        if (a_m_valid === 1'b1) begin
            a_mv_cnt++;
            a_mq.push_back(a_m_data);
        end
        if (b_m_valid === 1'b1) b_mv_cnt++;
    end

    // Independent tx line decoder: each entry is {stop_ok, data byte}.
    logic [8:0] a_fq[$];
    logic [8:0] b_fq[$];

    function automatic logic tx_of(input int ch);
        return (ch == 0) ? a_tx : b_tx;
    endfunction

    function automatic logic ready_of(input int ch);
        return (ch == 0) ? a_s_ready : b_s_ready;
    endfunction

    task automatic tx_decoder(input int ch, input int nstop);
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && tx_of(ch) === 1'b0) begin
                repeat (Cpp / 2) @(negedge clk);
                ok = (tx_of(ch) === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Cpp) @(negedge clk);
                    b[i] = tx_of(ch);
                end
                for (int s = 0; s < nstop; s++) begin
                    repeat (Cpp) @(negedge clk);
                    ok = ok & (tx_of(ch) === 1'b1);
                end
                if (ch == 0) a_fq.push_back({ok, b});
                else b_fq.push_back({ok, b});
            end
        end
    endtask

    initial tx_decoder(0, 1);
    initial tx_decoder(1, 2);

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input int ch, input logic [23:0] data);
        if (ch == 0) begin
            a_s_valid = 1'b1;
            a_s_data  = data;
        end else begin
            b_s_valid = 1'b1;
            b_s_data  = data[11:0];
        end
        @(negedge clk);
        a_s_valid = 1'b0;
        b_s_valid = 1'b0;
    endtask

    task automatic wait_ready(input int ch, output int cnt);
        cnt = 0;
        while (ready_of(ch) !== 1'b1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        a_rx_drv = 1'b0;
        repeat (Cpp) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            a_rx_drv = b[i];
            repeat (Cpp) @(negedge clk);
        end
        a_rx_drv = stop;
        repeat (Cpp) @(negedge clk);
        a_rx_drv = 1'b1;
        repeat (2 * Cpp) @(negedge clk);
    endtask

    typedef struct {
        logic [23:0] data;
        logic [7:0]  c0;
        logic [7:0]  c1;
        logic [7:0]  c2;
        logic [23:0] m_exp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cnt;
        int mv0;
        logic [8:0] got;
        logic [7:0] exp_c;

        vecs[0] = '{24'hA53CF0, 8'hF0, 8'h3C, 8'hA5, 24'hA53CF0};
        vecs[1] = '{24'h000000, 8'h00, 8'h00, 8'h00, 24'h000000};
        vecs[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
        vecs[3] = '{24'h123456, 8'h56, 8'h34, 8'h12, 24'h123456};
        vecs[4] = '{24'h800001, 8'h01, 8'h00, 8'h80, 24'h800001};

        rstn      = 1'b0;
        a_s_valid = 1'b0;
        a_s_data  = '0;
        a_loop    = 1'b1;
        a_rx_drv  = 1'b1;
        b_s_valid = 1'b0;
        b_s_data  = '0;

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(a_tx), 32'd1);
        check("rst_ready", 32'(a_s_ready), 32'd1);
        check("rst_mvalid", 32'(a_m_valid), 32'd0);
        check("rst_mdata", 32'(a_m_data), 32'd0);
        check("rst_b_tx", 32'(b_tx), 32'd1);
        check("rst_b_ready", 32'(b_s_ready), 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback vectors on the 24-bit instance.
        for (int v = 0; v < 5; v++) begin
            a_fq.delete();
            mv0 = a_mv_cnt;
            send(0, vecs[v].data);
            check("busy_cycles", 32'(a_s_ready), 32'd0);
            wait_ready(0, cnt);
            check("busy_len", 32'(cnt), 32'd480);
            repeat (20) @(negedge clk);
            check("nframes", 32'(a_fq.size()), 32'd3);
            for (int k = 0; k < 3; k++) begin
                exp_c = (k == 0) ? vecs[v].c0 : (k == 1) ? vecs[v].c1 : vecs[v].c2;
                got   = (k < a_fq.size()) ? a_fq[k] : 9'h000;
                check("frame", 32'(got), 32'({1'b1, exp_c}));
            end
            check("mvalid_cnt", 32'(a_mv_cnt - mv0), 32'd1);
            check("mdata", 32'(a_m_data), 32'(vecs[v].m_exp));
        end

        // Back-to-back words with s_valid held high.
        mv0 = a_mv_cnt;
        a_mq.delete();
        a_s_valid = 1'b1;
        a_s_data  = 24'h000001;
        @(negedge clk);
        a_s_data = 24'hFFFFFF;
        wait_ready(0, cnt);
        check("b2b_busy1", 32'(cnt), 32'd480);
        @(negedge clk);
        a_s_valid = 1'b0;
        check("b2b_start", 32'(a_tx), 32'd0);
        check("b2b_ready_low", 32'(a_s_ready), 32'd0);
        wait_ready(0, cnt);
        check("b2b_busy2", 32'(cnt), 32'd480);
        repeat (20) @(negedge clk);
        check("b2b_mvalid_cnt", 32'(a_mv_cnt - mv0), 32'd2);
        check("b2b_word0", 32'((a_mq.size() > 0) ? a_mq[0] : 24'hx), 32'h000001);
        check("b2b_word1", 32'((a_mq.size() > 1) ? a_mq[1] : 24'hx), 32'hFFFFFF);

        // 12-bit, two-stop-bit instance.
        b_fq.delete();
        mv0 = b_mv_cnt;
        send(1, 24'h000ABC);
        wait_ready(1, cnt);
        check("b_busy_len", 32'(cnt), 32'd352);
        repeat (20) @(negedge clk);
        check("b_nframes", 32'(b_fq.size()), 32'd2);
        check("b_frame0", 32'((b_fq.size() > 0) ? b_fq[0] : 9'h000), 32'h1BC);
        check("b_frame1", 32'((b_fq.size() > 1) ? b_fq[1] : 9'h000), 32'h10A);
        check("b_mvalid_cnt", 32'(b_mv_cnt - mv0), 32'd1);
        check("b_mdata", 32'(b_m_data), 32'hABC);

        // Short rx glitch, then a clean word driven by the bench.
        a_loop = 1'b0;
        repeat (4) @(negedge clk);
        mv0 = a_mv_cnt;
        a_rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        a_rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_mvalid", 32'(a_mv_cnt - mv0), 32'd0);
        drive_frame(8'hEE, 1'b1);
        drive_frame(8'hFF, 1'b1);
        drive_frame(8'hC0, 1'b1);
        check("glitch_mvalid_cnt", 32'(a_mv_cnt - mv0), 32'd1);
        check("glitch_mdata", 32'(a_m_data), 32'hC0FFEE);

        // Framing error after one good chunk drops the partial word.
        mv0 = a_mv_cnt;
        drive_frame(8'h55, 1'b1);
        drive_frame(8'h77, 1'b0);
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        check("ferr_no_early", 32'(a_mv_cnt - mv0), 32'd0);
        drive_frame(8'h33, 1'b1);
        check("ferr_mvalid_cnt", 32'(a_mv_cnt - mv0), 32'd1);
        check("ferr_mdata", 32'(a_m_data), 32'h332211);

        // Reset pulse in the middle of a transmitted frame.
        a_loop = 1'b1;
        repeat (4) @(negedge clk);
        send(0, 24'h5A5A5A);
        repeat (100) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(a_tx), 32'd1);
        check("midrst_ready", 32'(a_s_ready), 32'd1);
        check("midrst_mvalid", 32'(a_m_valid), 32'd0);
        check("midrst_mdata", 32'(a_m_data), 32'd0);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        a_fq.delete();
        mv0 = a_mv_cnt;
        send(0, 24'h0F1E2D);
        wait_ready(0, cnt);
        check("post_busy_len", 32'(cnt), 32'd480);
        repeat (20) @(negedge clk);
        check("post_nframes", 32'(a_fq.size()), 32'd3);
        check("post_frame0", 32'((a_fq.size() > 0) ? a_fq[0] : 9'h000), 32'h12D);
        check("post_mvalid_cnt", 32'(a_mv_cnt - mv0), 32'd1);
        check("post_mdata", 32'(a_m_data), 32'h0F1E2D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
